// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift/rotate unit: op and state
// encodings, default widths and the op legality check.
package shift_pkg;

    localparam int SHIFT_WIDTH = 16;
    localparam int SHIFT_CNT_W = $clog2(SHIFT_WIDTH);

    typedef enum logic [2:0] {
        SHOP_SLL = 3'b000,
        SHOP_SRL = 3'b001,
        SHOP_SRA = 3'b010,
        SHOP_ROL = 3'b011,
        SHOP_ROR = 3'b100
    } shop_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Codes above ROR are reserved; they pass the operand through untouched.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= 3'(SHOP_ROR));
    endfunction

endpackage

// File: rtl/shift_step1.sv
// One-position shift/rotate step: each output bit is a 2:1 mux between its
// lower and upper neighbour, with op-dependent fill at the two ends.
module shift_step1
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] step
);

    logic             left;
    logic             fill_lo;
    logic             fill_hi;
    logic [WIDTH-1:0] moved;

    always_comb begin
        left    = (op == SHOP_SLL) || (op == SHOP_ROL);
        fill_lo = (op == SHOP_ROL) ? data[WIDTH-1] : 1'b0;
        case (op)
            SHOP_SRA: fill_hi = data[WIDTH-1];
            SHOP_ROR: fill_hi = data[0];
            default:  fill_hi = 1'b0;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic from_lo;
        logic from_hi;

        if (i == 0) begin : g_lo_end
            assign from_lo = fill_lo;
        end else begin : g_lo_mid
            assign from_lo = data[i-1];
        end

        if (i == WIDTH - 1) begin : g_hi_end
            assign from_hi = fill_hi;
        end else begin : g_hi_mid
            assign from_hi = data[i+1];
        end

        assign moved[i] = left ? from_lo : from_hi;
    end

    assign step = op_is_legal(op) ? moved : data;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift/rotate controller: latches op/operand/count on start and
// applies one single-bit step per cycle until the down-counter expires.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start, result holds last value
//   ST_SHIFT | one step per cycle, counter decrements toward 1
//   ST_DONE  | single cycle, done (and err if op illegal) asserted
module shift_seq_ctrl
    import shift_pkg::*;
#(
    parameter int WIDTH = SHIFT_WIDTH,
    parameter int CNT_W = SHIFT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] cnt,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    state_e           state;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] work_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH-1:0] step_data;

    shift_step1 #(
        .WIDTH (WIDTH)
    ) u_step (
        .data (work_q),
        .op   (op_q),
        .step (step_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            op_q    <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (flush) begin
                // Abort wins over everything, including a same-cycle start.
                state   <= ST_IDLE;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            op_q   <= op;
                            work_q <= in_data;
                            cnt_q  <= cnt;
                            if (cnt == '0) begin
                                state   <= ST_DONE;
                                ready_q <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                err_q   <= !op_is_legal(op);
                            end else begin
                                state   <= ST_SHIFT;
                                ready_q <= 1'b0;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            state   <= ST_IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_SHIFT: begin
                        work_q <= step_data;
                        cnt_q  <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state   <= ST_DONE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= !op_is_legal(op_q);
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ready  = ready_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign result = work_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Scoreboard bench for shift_seq_ctrl: expectations queued at start, checked
// against result/err/done cycle when done is seen.
module tb_shift_seq_ctrl;
    import shift_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] in_data = '0;
    logic [3:0]   cnt = '0;
    logic         ready;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int busy_total = 0;
    int done_total = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    shift_seq_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .in_data (in_data),
        .cnt     (cnt),
        .flush   (flush),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .result  (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (busy) busy_total++;
        if (done) begin
            done_total++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'(0));
            end else begin
                e_mon = sb.pop_front();
                chk("result", 32'(result), 32'(e_mon.res));
                chk("err", 32'(err), 32'(e_mon.err));
                chk("done_cycle", cyc, e_mon.cyc);
                chk("ready_at_done", 32'(ready), 32'(1));
            end
        end
    end

    function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] d, input int n);
        logic [2*W-1:0] dd;
        logic [2*W-1:0] t;
        dd = {d, d};
        case (o)
            3'b000: return d << n;
            3'b001: return d >> n;
            3'b010: return $signed(d) >>> n;
            3'b011: begin t = dd << n; return t[2*W-1:W]; end
            3'b100: begin t = dd >> n; return t[W-1:0]; end
            default: return d;
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [W-1:0] d, input logic [3:0] n,
                         input logic [W-1:0] er, input logic ee);
        exp_t e;
        e.res = er;
        e.err = ee;
        e.cyc = cyc + int'(n) + 1;
        sb.push_back(e);
        start = 1'b1; op = o; in_data = d; cnt = n;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_timeout", sb.size(), 0);
    endtask

    task automatic run(input logic [2:0] o, input logic [W-1:0] d, input logic [3:0] n,
                       input logic [W-1:0] er, input logic ee);
        int b0;
        b0 = busy_total;
        issue(o, d, n, er, ee);
        drain();
        chk("busy_cycles", busy_total - b0, int'(n));
    endtask

    initial begin
        int d0;
        logic [2:0]   ro;
        logic [W-1:0] rd;
        logic [3:0]   rn;

        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_result", 32'(result), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(3'b000, 16'h8001, 4'd1, 16'h0002, 1'b0);
        run(3'b010, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
        run(3'b001, 16'h8000, 4'd15, 16'h0001, 1'b0);
        run(3'b100, 16'h0001, 4'd4, 16'h1000, 1'b0);
        run(3'b011, 16'h8001, 4'd1, 16'h0003, 1'b0);
        run(3'b001, 16'h1234, 4'd0, 16'h1234, 1'b0);

        // cnt=0 op followed by a start during its DONE cycle
        issue(3'b001, 16'h1234, 4'd0, 16'h1234, 1'b0);
        issue(3'b000, 16'h0001, 4'd2, 16'h0004, 1'b0);
        drain();

        run(3'b111, 16'hA5A5, 4'd3, 16'hA5A5, 1'b1);

        // start ignored in SHIFT, then flush
        d0 = done_total;
        start = 1'b1; op = 3'b000; in_data = 16'h00FF; cnt = 4'd8;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; op = 3'b001; in_data = 16'hFFFF; cnt = 4'd1;
        @(posedge clk); #1; start = 1'b0;
        flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_ready", 32'(ready), 32'(1));
        chk("flush_busy", 32'(busy), 32'(0));
        chk("flush_result_held", 32'(result), 32'(16'h03FC));
        repeat (12) @(posedge clk);
        #1;
        chk("flush_no_done", done_total - d0, 0);

        // flush and start together: start dropped
        start = 1'b1; flush = 1'b1; op = 3'b000; in_data = 16'h0001; cnt = 4'd2;
        @(posedge clk); #1; start = 1'b0; flush = 1'b0;
        chk("fs_ready", 32'(ready), 32'(1));
        chk("fs_busy", 32'(busy), 32'(0));
        chk("fs_result", 32'(result), 32'(16'h03FC));
        repeat (6) @(posedge clk);
        #1;
        chk("fs_no_done", done_total - d0, 0);

        for (int i = 0; i < 8; i++) begin
            ro = 3'($urandom_range(0, 4));
            rd = W'($urandom);
            rn = 4'($urandom_range(0, 15));
            run(ro, rd, rn, model(ro, rd, int'(rn)), 1'b0);
        end

        // asynchronous reset in the middle of a shift
        issue(3'b010, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'(1));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_done", 32'(done), 32'(0));
        chk("arst_err", 32'(err), 32'(0));
        chk("arst_result", 32'(result), 32'(0));
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(3'b100, 16'h00F0, 4'd8, 16'hF000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
